regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file (with its 4-bit position tags) between two write-back requesters.
  - Port A: ALU result path.
  - Port B: load/memory result path.
- Buffers one request per port and arbitrates round-robin.
- Drives registered RDaddr/RDdata/RegWrite/is_pos into the register file.
- Exports a per-register pending bitmap for issue-stage hazard checks.

---
 rtl/regfile_wb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single write port of the 32x32 register file (with its 4-bit
//   position tags) between two write-back requesters:
//     port A - ALU result path, port B - load/memory result path.
//   Each port owns a one-entry buffer; a round-robin grant moves one buffered
//   entry per cycle onto the registered register-file write stage.
//
// Ports
//   clk_i                     clock, all state updates on posedge
//   reset                     asynchronous, active-high reset
//   a_valid_i / a_ready_o     port A handshake
//   a_addr_i/a_data_i/a_pos_i port A destination, data, position tag
//   b_valid_i / b_ready_o     port B handshake
//   b_addr_i/b_data_i/b_pos_i port B destination, data, position tag
//   RDaddr_o/RDdata_o/is_pos_o/RegWrite_o  registered register-file write port
//   pending_o                 bit r set while a write to r is buffered or on the output stage
//   wb_count_o                saturating count of RegWrite_o cycles
//   conflict_count_o          saturating count of cycles with both buffers full
module regfile_wb_arbiter #(
  parameter int NREQ_W = 16
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [4:0]        a_addr_i,
  input  logic [31:0]       a_data_i,
  input  logic [3:0]        a_pos_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [4:0]        b_addr_i,
  input  logic [31:0]       b_data_i,
  input  logic [3:0]        b_pos_i,
  output logic [4:0]        RDaddr_o,
  output logic [31:0]       RDdata_o,
  output logic              RegWrite_o,
  output logic [3:0]        is_pos_o,
  output logic [31:0]       pending_o,
  output logic [NREQ_W-1:0] wb_count_o,
  output logic [NREQ_W-1:0] conflict_count_o
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  localparam logic [NREQ_W-1:0] CNT_MAX_C = {NREQ_W{1'b1}};
  localparam logic [NREQ_W-1:0] CNT_ONE_C = {{(NREQ_W-1){1'b0}}, 1'b1};

  logic        a_full_r, b_full_r;
  logic [4:0]  a_addr_r, b_addr_r;
  logic [31:0] a_data_r, b_data_r;
  logic [3:0]  a_pos_r,  b_pos_r;
  port_e       last_grant_r;

  logic        grant_a_s, grant_b_s;
  logic        a_acc_s, b_acc_s;

  logic [4:0]  rd_addr_r;
  logic [31:0] rd_data_r;
  logic        reg_write_r;
  logic [3:0]  is_pos_r;
  logic [NREQ_W-1:0] wb_count_r, conflict_count_r;

  // Round-robin grant from the buffer full flags; ties go to the port not served last.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case ({a_full_r, b_full_r})
      2'b10: grant_a_s = 1'b1;
      2'b01: grant_b_s = 1'b1;
      2'b11: begin
        if (last_grant_r == PORT_B) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // A buffer being drained this edge can take a new entry on the same edge.
  assign a_ready_o = ~reset & (~a_full_r | grant_a_s);
  assign b_ready_o = ~reset & (~b_full_r | grant_b_s);
  assign a_acc_s   = a_valid_i & a_ready_o;
  assign b_acc_s   = b_valid_i & b_ready_o;

  // Pending bitmap: buffered entries plus the write on the output stage; r0 never pends.
  assign pending_o = ((a_full_r    ? (32'd1 << a_addr_r)  : 32'd0) |
                      (b_full_r    ? (32'd1 << b_addr_r)  : 32'd0) |
                      (reg_write_r ? (32'd1 << rd_addr_r) : 32'd0)) & ~32'd1;

  // Port A one-entry buffer.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      a_full_r <= 1'b0;
      a_addr_r <= 5'd0;
      a_data_r <= 32'd0;
      a_pos_r  <= 4'd0;
    end else if (a_acc_s) begin
      a_full_r <= 1'b1;
      a_addr_r <= a_addr_i;
      a_data_r <= a_data_i;
      a_pos_r  <= a_pos_i;
    end else if (grant_a_s) begin
      a_full_r <= 1'b0;
    end
  end

  // Port B one-entry buffer.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      b_full_r <= 1'b0;
      b_addr_r <= 5'd0;
      b_data_r <= 32'd0;
      b_pos_r  <= 4'd0;
    end else if (b_acc_s) begin
      b_full_r <= 1'b1;
      b_addr_r <= b_addr_i;
      b_data_r <= b_data_i;
      b_pos_r  <= b_pos_i;
    end else if (grant_b_s) begin
      b_full_r <= 1'b0;
    end
  end

  // Output stage: load the granted entry; writes to r0 are consumed without a pulse.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      rd_addr_r    <= 5'd0;
      rd_data_r    <= 32'd0;
      is_pos_r     <= 4'd0;
      reg_write_r  <= 1'b0;
      last_grant_r <= PORT_B;
    end else if (grant_a_s) begin
      rd_addr_r    <= a_addr_r;
      rd_data_r    <= a_data_r;
      is_pos_r     <= a_pos_r;
      reg_write_r  <= (a_addr_r != 5'd0);
      last_grant_r <= PORT_A;
    end else if (grant_b_s) begin
      rd_addr_r    <= b_addr_r;
      rd_data_r    <= b_data_r;
      is_pos_r     <= b_pos_r;
      reg_write_r  <= (b_addr_r != 5'd0);
      last_grant_r <= PORT_B;
    end else begin
      reg_write_r  <= 1'b0;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wb_count_r       <= {NREQ_W{1'b0}};
      conflict_count_r <= {NREQ_W{1'b0}};
    end else begin
      if (reg_write_r && (wb_count_r != CNT_MAX_C)) begin
        wb_count_r <= wb_count_r + CNT_ONE_C;
      end
      if (a_full_r && b_full_r && (conflict_count_r != CNT_MAX_C)) begin
        conflict_count_r <= conflict_count_r + CNT_ONE_C;
      end
    end
  end

  assign RDaddr_o         = rd_addr_r;
  assign RDdata_o         = rd_data_r;
  assign is_pos_o         = is_pos_r;
  assign RegWrite_o       = reg_write_r;
  assign wb_count_o       = wb_count_r;
  assign conflict_count_o = conflict_count_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int NREQ_W = 16;
  localparam int CMAX = (1 << NREQ_W) - 1;

  logic clk_i = 1'b0;
  logic reset = 1'b1;
  logic a_valid_i = 1'b0, b_valid_i = 1'b0;
  logic a_ready_o, b_ready_o;
  logic [4:0] a_addr_i = 5'd0, b_addr_i = 5'd0;
  logic [31:0] a_data_i = 32'd0, b_data_i = 32'd0;
  logic [3:0] a_pos_i = 4'd0, b_pos_i = 4'd0;
  logic [4:0] RDaddr_o;
  logic [31:0] RDdata_o;
  logic RegWrite_o;
  logic [3:0] is_pos_o;
  logic [31:0] pending_o;
  logic [NREQ_W-1:0] wb_count_o, conflict_count_o;

  regfile_wb_arbiter #(.NREQ_W(NREQ_W)) dut (
    .clk_i(clk_i), .reset(reset),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i),
    .a_data_i(a_data_i), .a_pos_i(a_pos_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i),
    .b_data_i(b_data_i), .b_pos_i(b_pos_i),
    .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .RegWrite_o(RegWrite_o),
    .is_pos_o(is_pos_o), .pending_o(pending_o),
    .wb_count_o(wb_count_o), .conflict_count_o(conflict_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  pos;
  } req_t;

  // Reference model: per-port FIFO of depth one and a round-robin winner.
  req_t qa[$];
  req_t qb[$];
  int m_last;
  logic e_we;
  logic [4:0] e_addr;
  logic [31:0] e_data;
  logic [3:0] e_pos;
  int e_wb, e_conf;
  logic exp_ra, exp_rb, obs_ra, obs_rb;
  logic [31:0] obs_pend;
  logic obs_we;

  // Register file as seen by the consumer: captures on negedge.
  logic [31:0] rf [32];
  int we_seen = 0;
  always @(negedge clk_i) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (RegWrite_o) begin
      rf[RDaddr_o] <= RDdata_o;
      we_seen <= we_seen + 1;
    end
  end

  function automatic req_t mk(input logic [4:0] a, input logic [31:0] d, input logic [3:0] p);
    req_t r;
    r.addr = a; r.data = d; r.pos = p;
    return r;
  endfunction

  function automatic int winner();
    if (qa.size() > 0 && qb.size() > 0) return 1 - m_last;
    if (qa.size() > 0) return 0;
    if (qb.size() > 0) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = 32'd0;
    foreach (qa[i]) if (qa[i].addr != 5'd0) p[qa[i].addr] = 1'b1;
    foreach (qb[i]) if (qb[i].addr != 5'd0) p[qb[i].addr] = 1'b1;
    if (e_we) p[e_addr] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    m_last = 1;
    e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_pos = 4'd0;
    e_wb = 0; e_conf = 0;
  endtask

  task automatic model_edge(input logic av, input req_t ra, input logic bv, input req_t rb);
    int w;
    req_t g;
    w = winner();
    if (e_we && e_wb < CMAX) e_wb++;
    if (qa.size() > 0 && qb.size() > 0 && e_conf < CMAX) e_conf++;
    g = mk(5'd0, 32'd0, 4'd0);
    if (w == 0) g = qa.pop_front();
    else if (w == 1) g = qb.pop_front();
    if (w >= 0) begin
      e_addr = g.addr; e_data = g.data; e_pos = g.pos;
      e_we = (g.addr != 5'd0);
      m_last = w;
    end else begin
      e_we = 1'b0;
    end
    if (av && exp_ra) qa.push_back(ra);
    if (bv && exp_rb) qb.push_back(rb);
  endtask

  // One clock: drive inputs, sample ready/pending before the edge, advance model.
  task automatic cycle(input logic rst, input logic av, input req_t ra, input logic bv, input req_t rb);
    int w;
    reset = rst;
    a_valid_i = av; a_addr_i = ra.addr; a_data_i = ra.data; a_pos_i = ra.pos;
    b_valid_i = bv; b_addr_i = rb.addr; b_data_i = rb.data; b_pos_i = rb.pos;
    if (rst) model_reset();
    #1;
    w = winner();
    exp_ra = !rst && (qa.size() == 0 || w == 0);
    exp_rb = !rst && (qb.size() == 0 || w == 1);
    obs_ra = a_ready_o; obs_rb = b_ready_o;
    obs_pend = pending_o; obs_we = RegWrite_o;
    @(posedge clk_i);
    if (!rst) model_edge(av, ra, bv, rb);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b0, mk(5'd0, 32'd0, 4'd0));
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, mk(5'd1, 32'h1, 4'd1), 1'b1, mk(5'd2, 32'h2, 4'd2));
    cycle(1'b1, 1'b1, mk(5'd1, 32'h1, 4'd1), 1'b1, mk(5'd2, 32'h2, 4'd2));
    n_tests++; if (obs_ra !== 1'b0 || obs_rb !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", obs_ra, obs_rb); end
    n_tests++; if (RegWrite_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", RegWrite_o); end
    n_tests++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending_o); end
    n_tests++; if (wb_count_o !== 16'd0 || conflict_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d %0d want 0 0", wb_count_o, conflict_count_o); end
    n_tests++; if (RDaddr_o !== 5'd0 || RDdata_o !== 32'd0 || is_pos_o !== 4'd0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", RDaddr_o, RDdata_o, is_pos_o); end
    cycle(1'b0, 1'b1, mk(5'd1, 32'h1, 4'd1), 1'b1, mk(5'd2, 32'h2, 4'd2));
    n_tests++; if (obs_ra !== 1'b1 || obs_rb !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got a=%b b=%b want 1 1", obs_ra, obs_rb); end
    n_tests++; if (pending_o !== 32'h6) begin n_fail++; $display("FAIL post_reset_pending: got %h want 00000006", pending_o); end
    idle(4);
  endtask

  task automatic test_a_back_to_back();
    cycle(1'b1, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b0, mk(5'd0, 32'd0, 4'd0));
    for (int i = 0; i < 5; i++) begin
      logic [4:0] ad;
      logic [31:0] dd;
      ad = 5'd5 + 5'(i);
      dd = 32'h11 * 32'(i + 1);
      cycle(1'b0, i < 3, mk(ad, dd, 4'd3), 1'b0, mk(5'd0, 32'd0, 4'd0));
      if (i < 3) begin
        n_tests++; if (obs_ra !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, obs_ra); end
      end
      if (i >= 1 && i <= 3) begin
        n_tests++;
        if (RegWrite_o !== 1'b1 || RDaddr_o !== 5'd4 + 5'(i) || RDdata_o !== 32'h11 * 32'(i) || is_pos_o !== 4'd3) begin
          n_fail++; $display("FAIL b2b_write[%0d]: got we=%b addr=%0d data=%h pos=%0d want 1 %0d %h 3", i, RegWrite_o, RDaddr_o, RDdata_o, is_pos_o, 4 + i, 32'h11 * i);
        end
      end else if (i == 4) begin
        n_tests++; if (RegWrite_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got we=%b want 0", RegWrite_o); end
      end
    end
    n_tests++; if (wb_count_o !== 16'd3) begin n_fail++; $display("FAIL b2b_wbcount: got %0d want 3", wb_count_o); end
  endtask

  task automatic test_alternating();
    cycle(1'b1, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b0, mk(5'd0, 32'd0, 4'd0));
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b1, mk(5'd1, 32'(k), 4'd1), 1'b1, mk(5'd2, 32'(100 + k), 4'd2));
      if (k >= 1) begin
        n_tests++;
        if (obs_ra !== ((k % 2) == 1) || obs_rb !== ((k % 2) == 0)) begin
          n_fail++; $display("FAIL alt_ready[%0d]: got a=%b b=%b want %b %b", k, obs_ra, obs_rb, (k % 2) == 1, (k % 2) == 0);
        end
        n_tests++;
        if (RegWrite_o !== 1'b1 || RDaddr_o !== (((k % 2) == 1) ? 5'd1 : 5'd2)) begin
          n_fail++; $display("FAIL alt_grant[%0d]: got we=%b addr=%0d want 1 %0d", k, RegWrite_o, RDaddr_o, ((k % 2) == 1) ? 1 : 2);
        end
      end
      n_tests++; if (conflict_count_o !== 16'(k)) begin n_fail++; $display("FAIL alt_conflict[%0d]: got %0d want %0d", k, conflict_count_o, k); end
    end
    idle(4);
  endtask

  task automatic test_addr_zero();
    int wb0;
    cycle(1'b1, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b0, mk(5'd0, 32'd0, 4'd0));
    wb0 = int'(wb_count_o);
    cycle(1'b0, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b1, mk(5'd0, 32'hDEAD, 4'd7));
    n_tests++; if (obs_rb !== 1'b1) begin n_fail++; $display("FAIL zero_accept: got ready %b want 1", obs_rb); end
    n_tests++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL zero_pending: got %h want 0", pending_o); end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_tests++; if (RegWrite_o !== 1'b0 || pending_o[0] !== 1'b0) begin n_fail++; $display("FAIL zero_write[%0d]: got we=%b p0=%b want 0 0", i, RegWrite_o, pending_o[0]); end
    end
    n_tests++; if (int'(wb_count_o) !== wb0) begin n_fail++; $display("FAIL zero_wbcount: got %0d want %0d", wb_count_o, wb0); end
  endtask

  task automatic test_same_addr();
    cycle(1'b1, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b0, mk(5'd0, 32'd0, 4'd0));
    cycle(1'b0, 1'b1, mk(5'd9, 32'hAAAA, 4'd1), 1'b1, mk(5'd9, 32'hBBBB, 4'd2));
    n_tests++; if (pending_o !== 32'h200) begin n_fail++; $display("FAIL same_pending0: got %h want 00000200", pending_o); end
    idle(1);
    n_tests++; if (RegWrite_o !== 1'b1 || RDdata_o !== 32'hAAAA || pending_o[9] !== 1'b1) begin n_fail++; $display("FAIL same_first: got we=%b data=%h p9=%b want 1 aaaa 1", RegWrite_o, RDdata_o, pending_o[9]); end
    idle(1);
    n_tests++; if (RegWrite_o !== 1'b1 || RDdata_o !== 32'hBBBB || pending_o[9] !== 1'b1) begin n_fail++; $display("FAIL same_second: got we=%b data=%h p9=%b want 1 bbbb 1", RegWrite_o, RDdata_o, pending_o[9]); end
    idle(2);
    n_tests++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL same_retired: got %h want 0", pending_o); end
    n_tests++; if (rf[9] !== 32'hBBBB) begin n_fail++; $display("FAIL same_rf: got %h want 0000bbbb", rf[9]); end
  endtask

  task automatic test_reset_mid();
    int seen0;
    cycle(1'b1, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b0, mk(5'd0, 32'd0, 4'd0));
    cycle(1'b0, 1'b1, mk(5'd3, 32'h33, 4'd1), 1'b1, mk(5'd4, 32'h44, 4'd2));
    n_tests++; if (pending_o !== 32'h18) begin n_fail++; $display("FAIL mid_full: got pending %h want 00000018", pending_o); end
    seen0 = we_seen;
    cycle(1'b1, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b0, mk(5'd0, 32'd0, 4'd0));
    n_tests++; if (obs_pend !== 32'd0 || obs_we !== 1'b0) begin n_fail++; $display("FAIL mid_async: got pending %h we %b want 0 0", obs_pend, obs_we); end
    idle(3);
    n_tests++; if (we_seen !== seen0) begin n_fail++; $display("FAIL mid_nowrite: got %0d writes want %0d", we_seen, seen0); end
    n_tests++; if (rf[3] !== 32'd0 || rf[4] !== 32'd0) begin n_fail++; $display("FAIL mid_rf: got %h %h want 0 0", rf[3], rf[4]); end
  endtask

  task automatic test_random();
    cycle(1'b1, 1'b0, mk(5'd0, 32'd0, 4'd0), 1'b0, mk(5'd0, 32'd0, 4'd0));
    for (int k = 0; k < 400; k++) begin
      logic rst, av, bv;
      req_t ra, rb;
      rst = ($urandom_range(59, 0) == 0);
      av = ($urandom_range(9, 0) < 7);
      bv = ($urandom_range(9, 0) < 6);
      ra = mk(5'($urandom_range(31, 0)), $urandom, 4'($urandom_range(15, 0)));
      rb = mk(5'($urandom_range(31, 0)), $urandom, 4'($urandom_range(15, 0)));
      cycle(rst, av, ra, bv, rb);
      n_tests++; if (obs_ra !== exp_ra || obs_rb !== exp_rb) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", k, obs_ra, obs_rb, exp_ra, exp_rb); end
      n_tests++; if (RegWrite_o !== e_we) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b want %b", k, RegWrite_o, e_we); end
      if (e_we) begin
        n_tests++;
        if (RDaddr_o !== e_addr || RDdata_o !== e_data || is_pos_o !== e_pos) begin
          n_fail++; $display("FAIL rnd_data[%0d]: got %0d %h %0d want %0d %h %0d", k, RDaddr_o, RDdata_o, is_pos_o, e_addr, e_data, e_pos);
        end
      end
      n_tests++; if (pending_o !== exp_pending()) begin n_fail++; $display("FAIL rnd_pending[%0d]: got %h want %h", k, pending_o, exp_pending()); end
      n_tests++; if (int'(wb_count_o) !== e_wb || int'(conflict_count_o) !== e_conf) begin n_fail++; $display("FAIL rnd_counts[%0d]: got %0d %0d want %0d %0d", k, wb_count_o, conflict_count_o, e_wb, e_conf); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_a_back_to_back();
    test_alternating();
    test_addr_zero();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
